// File: rtl/i2c_target_rx.sv
// I2C target receiver: decodes START/STOP, ACKs a write to TARGET_ADDR and
// assembles two data bytes into one 16-bit word with a single-cycle strobe.
module i2c_target_rx #(
   parameter logic [6:0] TARGET_ADDR = 7'h42
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_scl,
   input  logic        i_sda,
   output logic        o_sda_en,
   output logic [15:0] o_data,
   output logic        o_valid,
   output logic        o_busy
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ACK_A,
      BYTE_HI,
      ACK_HI,
      BYTE_LO,
      ACK_LO,
      IGNORE
   } state_t;

   state_t      state;
   logic        scl_s1, scl_s2, scl_prev;
   logic        sda_s1, sda_s2, sda_prev;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift;
   logic [7:0]  hi_byte;
   logic        word_done;
   logic        scl_rise, scl_fall;
   logic        start_cond, stop_cond;
   logic [7:0]  byte_next;

   // Synchronizers idle high so a reset never looks like a bus condition.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         scl_s1   <= 1'b1;
         scl_s2   <= 1'b1;
         scl_prev <= 1'b1;
         sda_s1   <= 1'b1;
         sda_s2   <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_s1   <= i_scl;
         scl_s2   <= scl_s1;
         scl_prev <= scl_s2;
         sda_s1   <= i_sda;
         sda_s2   <= sda_s1;
         sda_prev <= sda_s2;
      end
   end

   assign scl_rise   = scl_s2 & ~scl_prev;
   assign scl_fall   = ~scl_s2 & scl_prev;
   assign start_cond = scl_s2 & sda_prev & ~sda_s2;
   assign stop_cond  = scl_s2 & ~sda_prev & sda_s2;
   assign byte_next  = {shift[6:0], sda_s2};

   // Bus conditions take priority over any SCL edge in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         shift     <= 8'h00;
         hi_byte   <= 8'h00;
         word_done <= 1'b0;
         o_sda_en  <= 1'b0;
         o_data    <= 16'h0000;
         o_valid   <= 1'b0;
         o_busy    <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (start_cond) begin
            state     <= ADDR;
            bit_cnt   <= 3'd0;
            word_done <= 1'b0;
            o_sda_en  <= 1'b0;
            o_busy    <= 1'b1;
         end else if (stop_cond) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            word_done <= 1'b0;
            o_sda_en  <= 1'b0;
            o_busy    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  o_sda_en <= 1'b0;
               end
               ADDR: begin
                  if (scl_rise) begin
                     shift   <= byte_next;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (byte_next[7:1] == TARGET_ADDR && !byte_next[0])
                           state <= ACK_A;
                        else
                           state <= IGNORE;
                     end
                  end
               end
               // First fall after the 8th bit grabs SDA, the next one lets it go.
               ACK_A, ACK_HI, ACK_LO: begin
                  if (scl_fall) begin
                     if (!o_sda_en) begin
                        o_sda_en <= 1'b1;
                     end else begin
                        o_sda_en <= 1'b0;
                        case (state)
                           ACK_A:   state <= BYTE_HI;
                           ACK_HI:  state <= BYTE_LO;
                           default: state <= IGNORE;
                        endcase
                     end
                  end
               end
               BYTE_HI: begin
                  if (scl_rise) begin
                     shift   <= byte_next;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        hi_byte <= byte_next;
                        state   <= ACK_HI;
                     end
                  end
               end
               BYTE_LO: begin
                  if (word_done) begin
                     o_data    <= {hi_byte, shift};
                     o_valid   <= 1'b1;
                     word_done <= 1'b0;
                     state     <= ACK_LO;
                  end else if (scl_rise) begin
                     shift   <= byte_next;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7)
                        word_done <= 1'b1;
                  end
               end
               IGNORE: begin
                  o_sda_en <= 1'b0;
               end
               default: begin
                  state    <= IDLE;
                  o_sda_en <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: a bit-banged I2C master drives SCL/SDA
// over an open-drain bus and checks ACKs, assembled words and strobes.
module tb_i2c_target_rx;

   localparam int Q = 10;
   localparam int H = 20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        scl;
   logic        sda_m;
   logic        sda_bus;
   logic        sda_en;
   logic [15:0] data;
   logic        valid;
   logic        busy;

   int total = 0;
   int bad = 0;
   int valid_cycles = 0;
   int en_cycles = 0;
   logic a0, a1, a2, a3;

   always #5 clk = ~clk;

   assign sda_bus = sda_m & ~sda_en;

   i2c_target_rx #(.TARGET_ADDR(7'h42)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_scl   (scl),
      .i_sda   (sda_bus),
      .o_sda_en(sda_en),
      .o_data  (data),
      .o_valid (valid),
      .o_busy  (busy)
   );

   always @(posedge clk) begin
      if (valid) valid_cycles++;
      if (sda_en) en_cycles++;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; scl = 1'b1; wait_cyc(H);
      sda_m = 1'b0; wait_cyc(H);
      scl = 1'b0; wait_cyc(Q);
   endtask

   task automatic bus_rstart();
      sda_m = 1'b1; wait_cyc(Q);
      scl = 1'b1; wait_cyc(H);
      sda_m = 1'b0; wait_cyc(H);
      scl = 1'b0; wait_cyc(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_cyc(Q);
      scl = 1'b1; wait_cyc(H);
      sda_m = 1'b1; wait_cyc(H);
   endtask

   task automatic send_bits(input logic [7:0] val, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         sda_m = val[i]; wait_cyc(Q);
         scl = 1'b1; wait_cyc(H);
         scl = 1'b0; wait_cyc(Q);
      end
   endtask

   // Ninth clock: master releases SDA and samples it mid-high.
   task automatic ack_bit(output logic acked);
      sda_m = 1'b1; wait_cyc(Q);
      scl = 1'b1; wait_cyc(Q);
      acked = (sda_bus == 1'b0);
      wait_cyc(Q);
      scl = 1'b0; wait_cyc(Q);
   endtask

   task automatic apply_stimulus(input logic [7:0] val, output logic acked);
      send_bits(val, 8);
      ack_bit(acked);
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
      wait_cyc(5);
      check_output("reset_sda_en", {31'd0, sda_en}, 32'd0);
      check_output("reset_data", {16'd0, data}, 32'h0000);
      check_output("reset_valid", {31'd0, valid}, 32'd0);
      check_output("reset_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      wait_cyc(H);

      $display("[TB] write 0x42 A5 3C");
      valid_cycles = 0;
      bus_start();
      check_output("t1_busy_start", {31'd0, busy}, 32'd1);
      apply_stimulus(8'h84, a0);
      apply_stimulus(8'hA5, a1);
      apply_stimulus(8'h3C, a2);
      check_output("t1_acks", {29'd0, a0, a1, a2}, 32'h7);
      bus_stop();
      check_output("t1_data", {16'd0, data}, 32'hA53C);
      check_output("t1_valid_cycles", valid_cycles, 32'd1);
      check_output("t1_busy_stop", {31'd0, busy}, 32'd0);

      $display("[TB] write to 0x43");
      valid_cycles = 0; en_cycles = 0;
      bus_start();
      apply_stimulus(8'h86, a0);
      apply_stimulus(8'h11, a1);
      apply_stimulus(8'h22, a2);
      bus_stop();
      check_output("t2_acks", {29'd0, a0, a1, a2}, 32'h0);
      check_output("t2_en_cycles", en_cycles, 32'd0);
      check_output("t2_valid_cycles", valid_cycles, 32'd0);
      check_output("t2_data", {16'd0, data}, 32'hA53C);

      $display("[TB] read from 0x42");
      en_cycles = 0;
      bus_start();
      apply_stimulus(8'h85, a0);
      apply_stimulus(8'h00, a1);
      check_output("t3_acks", {30'd0, a0, a1}, 32'h0);
      check_output("t3_busy_ignore", {31'd0, busy}, 32'd1);
      bus_stop();
      check_output("t3_en_cycles", en_cycles, 32'd0);
      check_output("t3_busy_stop", {31'd0, busy}, 32'd0);

      $display("[TB] single byte then stop");
      valid_cycles = 0;
      bus_start();
      apply_stimulus(8'h84, a0);
      apply_stimulus(8'hA5, a1);
      bus_stop();
      check_output("t4_acks", {30'd0, a0, a1}, 32'h3);
      check_output("t4_valid_cycles", valid_cycles, 32'd0);
      check_output("t4_data", {16'd0, data}, 32'hA53C);

      $display("[TB] repeated start mid byte");
      valid_cycles = 0;
      bus_start();
      apply_stimulus(8'h84, a0);
      send_bits(8'h55, 4);
      bus_rstart();
      apply_stimulus(8'h84, a1);
      apply_stimulus(8'hBE, a2);
      apply_stimulus(8'hEF, a3);
      bus_stop();
      check_output("t5_acks", {28'd0, a0, a1, a2, a3}, 32'hF);
      check_output("t5_data", {16'd0, data}, 32'hBEEF);
      check_output("t5_valid_cycles", valid_cycles, 32'd1);

      $display("[TB] reset during ACK_HI");
      bus_start();
      apply_stimulus(8'h84, a0);
      send_bits(8'h77, 8);
      check_output("t6_ack_driven", {31'd0, sda_en}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_output("t6_sda_en_reset", {31'd0, sda_en}, 32'd0);
      check_output("t6_data_reset", {16'd0, data}, 32'h0000);
      wait_cyc(3);
      scl = 1'b1; sda_m = 1'b1;
      rst_n = 1'b1;
      wait_cyc(H);
      valid_cycles = 0;
      bus_start();
      apply_stimulus(8'h84, a0);
      apply_stimulus(8'h01, a1);
      apply_stimulus(8'h02, a2);
      apply_stimulus(8'h33, a3);
      bus_stop();
      check_output("t6_acks", {28'd0, a0, a1, a2, a3}, 32'hE);
      check_output("t6_data", {16'd0, data}, 32'h0102);
      check_output("t6_valid_cycles", valid_cycles, 32'd1);
      check_output("t6_busy_stop", {31'd0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
